// File: rtl/gpu_vram_fill_controller_if.sv
// Bundles the register-block side (CPU writes and fill command) and the VRAM write side of the fill controller.
interface gpu_vram_fill_controller_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_vram_addr;
  logic [DATA_W-1:0] cpu_vram_data;
  logic              cpu_vram_we;
  logic              fill_start;
  logic              fill_abort;
  logic [ADDR_W-1:0] fill_base_addr;
  logic [7:0]        fill_width;
  logic [7:0]        fill_height;
  logic [7:0]        fill_stride;
  logic [DATA_W-1:0] fill_value;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic              vram_we;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output cpu_vram_addr, cpu_vram_data, cpu_vram_we,
    output fill_start, fill_abort, fill_base_addr, fill_width, fill_height, fill_stride, fill_value,
    input  vram_addr, vram_data, vram_we, fill_busy, fill_done
  );

  modport slave (
    input  cpu_vram_addr, cpu_vram_data, cpu_vram_we,
    input  fill_start, fill_abort, fill_base_addr, fill_width, fill_height, fill_stride, fill_value,
    output vram_addr, vram_data, vram_we, fill_busy, fill_done
  );
endinterface

// File: rtl/gpu_vram_fill_controller.sv
// Shares the VRAM write port between CPU writes and a rectangle-fill engine; 1-cycle registered write path.
// CPU writes always win; the fill engine simply holds its counters in any cycle the CPU writes.
module gpu_vram_fill_controller #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic                        clk_cpu,
  input  logic                        rst_n,
  gpu_vram_fill_controller_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;
  logic              vram_we_q, vram_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        width_q, width_d;
  logic [7:0]        height_q, height_d;
  logic [7:0]        stride_q, stride_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;

  logic              col_last;
  logic              row_last;
  logic [ADDR_W-1:0] stride_ext;

  assign col_last   = (col_q == width_q - 8'd1);
  assign row_last   = (row_q == height_q - 8'd1);
  assign stride_ext = {{(ADDR_W-8){1'b0}}, stride_q};

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fill_start) begin
          state_d = (bus.fill_width != 8'd0 && bus.fill_height != 8'd0) ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (bus.fill_abort) begin
          state_d = S_IDLE;
        end else if (!bus.cpu_vram_we && col_last && row_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    vram_we_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    value_d     = value_q;
    col_d       = col_q;
    row_d       = row_q;
    cur_addr_d  = cur_addr_q;
    row_addr_d  = row_addr_q;

    if (bus.cpu_vram_we) begin
      vram_addr_d = bus.cpu_vram_addr;
      vram_data_d = bus.cpu_vram_data;
      vram_we_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.fill_start) begin
          width_d    = bus.fill_width;
          height_d   = bus.fill_height;
          stride_d   = bus.fill_stride;
          value_d    = bus.fill_value;
          col_d      = 8'd0;
          row_d      = 8'd0;
          cur_addr_d = bus.fill_base_addr;
          row_addr_d = bus.fill_base_addr;
          busy_d     = 1'b1;
        end
      end
      S_FILL: begin
        if (bus.fill_abort) begin
          busy_d = 1'b0;
        end else if (!bus.cpu_vram_we) begin
          vram_addr_d = cur_addr_q;
          vram_data_d = value_q;
          vram_we_d   = 1'b1;
          // Row wrap jumps from the saved row start so stride is exact regardless of width.
          if (col_last) begin
            col_d      = 8'd0;
            row_d      = row_q + 8'd1;
            row_addr_d = row_addr_q + stride_ext;
            cur_addr_d = row_addr_q + stride_ext;
          end else begin
            col_d      = col_q + 8'd1;
            cur_addr_d = cur_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = !bus.fill_abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr_q <= '0;
      vram_data_q <= '0;
      vram_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      width_q     <= 8'd0;
      height_q    <= 8'd0;
      stride_q    <= 8'd0;
      value_q     <= '0;
      col_q       <= 8'd0;
      row_q       <= 8'd0;
      cur_addr_q  <= '0;
      row_addr_q  <= '0;
    end else begin
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      vram_we_q   <= vram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      value_q     <= value_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cur_addr_q  <= cur_addr_d;
      row_addr_q  <= row_addr_d;
    end
  end

  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_data = vram_data_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.fill_busy = busy_q;
  assign bus.fill_done = done_q;

endmodule

// File: doc/gpu_vram_fill_controller.md
Name: gpu_vram_fill_controller

Overview:
Controller for the CPU-side write port of the graphics VRAM. It shares that port between the graphics register interface (CPU writes and burst writes) and a hardware rectangle-fill engine. The fill engine writes a constant byte over a width x height byte region with a programmable row stride. CPU writes always take priority, and the fill engine stalls around them. The block sits between gpu_graphics_registers and the write side of gpu_graphics_vram in the clk_cpu domain.

Parameters:
ADDR_W, 15, VRAM byte-address width (32KB).
DATA_W, 8, VRAM data width.

Ports:
clk_cpu  input  1  CPU-domain clock; all logic is on its rising edge
rst_n  input  1  asynchronous, active-low reset
cpu_vram_addr  input  ADDR_W  CPU write address from the register block
cpu_vram_data  input  DATA_W  CPU write data
cpu_vram_we  input  1  CPU write request; one write per high cycle
fill_start  input  1  start pulse; sampled only in IDLE
fill_abort  input  1  abort request; effective only while busy
fill_base_addr  input  ADDR_W  top-left byte address
fill_width  input  8  bytes per row (0 = empty fill)
fill_height  input  8  row count (0 = empty fill)
fill_stride  input  8  bytes between row starts
fill_value  input  DATA_W  byte value written
vram_addr  output  ADDR_W  registered VRAM write address
vram_data  output  DATA_W  registered VRAM write data
vram_we  output  1  registered VRAM write enable
fill_busy  output  1  high from the accepted start until completion or abort
fill_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock): all outputs are 0, state is IDLE, and all latched parameters and counters are 0.
- States:
  - IDLE -> FILL on fill_start when width != 0 and height != 0.
  - IDLE -> DONE on fill_start when width = 0 or height = 0.
  - FILL -> DONE after the last write is issued.
  - DONE -> IDLE unconditionally.
  - FILL or DONE -> IDLE on fill_abort.
- Start edge: latch base, width, height, stride and value; fill_busy <= 1. Input changes after that edge are ignored until the next start.
- Output register: every edge loads vram_addr, vram_data and vram_we. Latency is 1 cycle from the request cycle to the VRAM write.
  - When no write is issued, vram_we <= 0; vram_addr and vram_data hold their values.
- Priority:
  - cpu_vram_we = 1: the CPU write is issued regardless of state. In FILL the fill engine stalls that cycle and its counters hold.
  - In FILL with cpu_vram_we = 0: issue the fill write (addr = cur_addr, data = latched value), then advance.
- Advance:
  - col++ and cur_addr++.
  - When col = width-1: col <= 0, row++, row_addr <= row_addr + stride, cur_addr <= row_addr + stride.
  - When row = height-1 and col = width-1: state <= DONE.
- Address arithmetic is modulo 2^ADDR_W; the address wraps 0x7FFF -> 0x0000 silently.
- Total fill writes = width*height (at most 65025). No write is skipped or duplicated regardless of CPU stalls.
- DONE edge: fill_done <= 1 for exactly one cycle, fill_busy <= 0, state <= IDLE.
  - The last fill write occurs at edge e; done and busy-clear occur at edge e+1.
  - Empty fill: start at edge s, done at edge s+1, no writes.
- fill_start while busy: ignored, no restart.
- fill_abort in FILL or DONE: state <= IDLE and fill_busy <= 0 at the next edge. No fill_done pulse and no further fill writes. A fill write issued at the abort edge itself is suppressed.
- fill_abort in IDLE: ignored. fill_start and fill_abort together in IDLE: the start is accepted.
- A CPU write in the same cycle as start, abort or DONE is still issued normally.
- A new start is accepted in the cycle after fill_done or after an abort.

Test Plan:
- Basic fill: base=0x0100, w=4, h=2, stride=40, value=0xAA, no CPU traffic -> 8 consecutive vram_we cycles at 0x0100-0x0103 then 0x0128-0x012B, data 0xAA. fill_done pulses one cycle after the last write; fill_busy falls on the same edge.
- CPU priority: same fill, with cpu_vram_we (0x7000, 0x55) in the cycle of the 3rd fill write -> output sequence 0x0100, 0x0101, 0x7000/0x55, 0x0102, ... for 9 writes total, with no fill address missing or repeated.
- Wrap: base=0x7FFE, w=4, h=1 -> writes at 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Empty fill: w=0, h=5 -> no vram_we; fill_busy high for 1 cycle; fill_done one edge after start. A start while busy (during the basic fill) is ignored.
- Abort: abort after 3 fill writes of the basic fill -> no further fill writes, fill_busy low at the next edge, no fill_done. A new start next cycle runs correctly from its own base.
- Reset: assert rst_n low mid-fill between clock edges -> vram_we, fill_busy and fill_done go to 0 immediately. After release, the block is IDLE with no residual writes.
